uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arb_rr_pick.sv | 31 +++
 rtl/uart_tx_arb.sv | 120 ++++++++++++
 tb/tb_uart_tx_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, byte type
// and the default end-of-packet character.
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   typedef logic [7:0] byte_t;

   localparam byte_t EOP_DEFAULT = 8'h0A;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: scans the request vector starting at ptr
// and returns the first set bit as a one-hot grant plus its index.
module rr_pick #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     any
);

   localparam int PW = $clog2(N_REQ);

   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = PW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte streams.
// Optional idle-owner timeout release is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int    N_REQ     = 2,
   parameter int    MAX_BURST = 16,
   parameter byte_t EOP_CHAR  = EOP_DEFAULT,
   parameter int    TIMEOUT   = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               busy
);

   localparam int PW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 4 || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT < 1) begin : g_bad_param
      $error("uart_tx_arb: parameter out of range");
   end

   arb_state_t        state;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     next_ptr;
   logic [7:0]        burst;
   logic [N_REQ-1:0]  pick_grant;
   logic [PW-1:0]     pick_idx;
   logic              pick_any;
   byte_t             owner_data;
   logic              xfer;
   logic              last_byte;
   logic              release_now;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Handshake: a byte moves on a cycle with tx_valid && tx_ready. The owner's
   // req_ready mirrors tx_ready, so the requester pops exactly the byte the UART takes.
   assign owner_data = req_data[int'(owner)*8 +: 8];
   assign tx_valid   = (state == LOCK) && req_valid[owner];
   assign tx_data    = (state == LOCK) ? owner_data : 8'h00;
   assign xfer       = tx_valid && tx_ready;

   always_comb begin
      req_ready = '0;
      if (state == LOCK) req_ready[owner] = tx_ready;
   end

   assign last_byte = xfer && ((owner_data == EOP_CHAR) || (burst == 8'(MAX_BURST - 1)));
   assign next_ptr  = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          timeout_hit;

   // Counts consecutive owned cycles without a transfer.
   assign timeout_hit = !xfer && (tcnt == TW'(TIMEOUT - 1));
   assign release_now = last_byte || timeout_hit;
`else
   assign release_now = last_byte;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         burst <= '0;
         grant <= '0;
         busy  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         tcnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state <= LOCK;
                  owner <= pick_idx;
                  grant <= pick_grant;
                  busy  <= 1'b1;
                  burst <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  tcnt  <= '0;
`endif
               end
            end
            LOCK: begin
               if (xfer) burst <= burst + 8'd1;
`ifdef UART_TX_ARB_TIMEOUT_EN
               tcnt <= xfer ? '0 : tcnt + 1'b1;
`endif
               // Advancing ptr past the old owner puts it last in the next scan.
               if (release_now) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
                  ptr   <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: two-requester instance with a byte
// scoreboard, plus a three-requester instance for pointer wrap.
module tb_uart_tx_arb;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        tx_ready_next;
   logic [1:0]  grant;
   logic        busy;

   logic [2:0]  req_valid3;
   logic [23:0] req_data3;
   logic [2:0]  req_ready3;
   logic        tx_valid3;
   logic [7:0]  tx_data3;
   logic        tx_ready3;
   logic [2:0]  grant3;
   logic        busy3;

   uart_tx_arb #(.N_REQ(2), .MAX_BURST(16), .EOP_CHAR(8'h0A), .TIMEOUT(1000)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .grant(grant), .busy(busy)
   );

   uart_tx_arb #(.N_REQ(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data3),
      .req_ready(req_ready3), .tx_valid(tx_valid3), .tx_data(tx_data3),
      .tx_ready(tx_ready3), .grant(grant3), .busy(busy3)
   );

   logic [7:0] src0[$], src1[$];
   logic [7:0] exp_q0[$], exp_q1[$];
   int total = 0;
   int bad   = 0;

   task automatic drive();
      req_valid[0]   = (src0.size() > 0);
      req_valid[1]   = (src1.size() > 0);
      req_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
      req_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
      tx_ready       = tx_ready_next;
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #1;
   endtask

   task automatic push0(input logic [7:0] b);
      src0.push_back(b);
      exp_q0.push_back(b);
   endtask

   task automatic push1(input logic [7:0] b);
      src1.push_back(b);
      exp_q1.push_back(b);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      src0.delete(); src1.delete(); exp_q0.delete(); exp_q1.delete();
      tx_ready_next = 1'b1;
      drive();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic drain(output int n);
      n = 0;
      while ((src0.size() > 0 || src1.size() > 0 || busy) && n < 300) begin
         step();
         n++;
      end
   endtask

   // Scoreboard: every accepted byte must be the next expected byte of the granted requester.
   always @(negedge clk) begin
      #2;
      if (!rst && tx_valid && tx_ready) begin
         total++;
         if (grant == 2'b01 && exp_q0.size() > 0) begin
            if (tx_data !== exp_q0[0]) begin
               bad++;
               $display("FAIL sb_req0 got=%h exp=%h", tx_data, exp_q0[0]);
            end
            void'(exp_q0.pop_front());
            void'(src0.pop_front());
         end else if (grant == 2'b10 && exp_q1.size() > 0) begin
            if (tx_data !== exp_q1[0]) begin
               bad++;
               $display("FAIL sb_req1 got=%h exp=%h", tx_data, exp_q1[0]);
            end
            void'(exp_q1.pop_front());
            void'(src1.pop_front());
         end else begin
            bad++;
            $display("FAIL sb_unexpected grant=%b data=%h", grant, tx_data);
         end
      end
   end

   task automatic test_reset();
      int n;
      rst = 1'b1;
      tx_ready_next = 1'b1;
      drive();
      repeat (2) @(negedge clk);
      #1;
      total += 4;
      if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", grant); end
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) push0(8'h41 + 8'(k));
      repeat (3) step();
      total++;
      if (tx_valid !== 1'b1) begin bad++; $display("FAIL rst_midpkt_valid got=%b exp=1", tx_valid); end
      rst = 1'b1;
      #1;
      total += 3;
      if (grant !== 2'b00) begin bad++; $display("FAIL rst_async_grant got=%b exp=00", grant); end
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_async_tx_valid got=%b exp=0", tx_valid); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
      src0.delete(); exp_q0.delete();
      push0(8'h31); push0(8'h0A);
      drive();
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (grant !== 2'b00) begin bad++; $display("FAIL rst_release_idle got=%b exp=00", grant); end
      step();
      total++;
      if (grant !== 2'b01) begin bad++; $display("FAIL rst_first_grant got=%b exp=01", grant); end
      drain(n);
      total++;
      if (n >= 300 || exp_q0.size() != 0) begin bad++; $display("FAIL rst_drain steps=%0d left=%0d exp=0", n, exp_q0.size()); end
   endtask

   task automatic test_single();
      int eop_step = 0;
      int busy_after = -1;
      push0(8'h48); push0(8'h69); push0(8'h0A);
      for (int s = 1; s <= 20 && busy_after < 0; s++) begin
         step();
         total++;
         if (req_ready[1] !== 1'b0) begin bad++; $display("FAIL single_rdy1 got=%b exp=0", req_ready[1]); end
         if (eop_step != 0) busy_after = int'(busy);
         else if (tx_valid && tx_ready && tx_data == 8'h0A) eop_step = s;
      end
      total += 2;
      if (eop_step != 4) begin bad++; $display("FAIL single_eop_step got=%0d exp=4", eop_step); end
      if (busy_after != 0) begin bad++; $display("FAIL single_busy_fall got=%0d exp=0", busy_after); end
   endtask

   task automatic test_fairness();
      int seg_idx = 0, seg_cnt = 0, idle_run = 0;
      logic [1:0] prev = 2'b00;
      logic [1:0] exp_g;
      do_reset();
      for (int k = 0; k < 32; k++) begin
         push0(8'h80 + 8'(k));
         push1(8'hC0 + 8'(k));
      end
      for (int s = 0; s < 200 && seg_idx < 4; s++) begin
         step();
         if (grant != 2'b00 && prev == 2'b00) begin
            exp_g = (seg_idx % 2 == 0) ? 2'b01 : 2'b10;
            total += 2;
            if (grant !== exp_g) begin bad++; $display("FAIL fair_owner seg=%0d got=%b exp=%b", seg_idx, grant, exp_g); end
            if (idle_run != 1) begin bad++; $display("FAIL fair_gap seg=%0d got=%0d exp=1", seg_idx, idle_run); end
            seg_cnt = 0;
         end
         if (grant == 2'b00 && prev != 2'b00) begin
            total++;
            if (seg_cnt != 16) begin bad++; $display("FAIL fair_burst seg=%0d got=%0d exp=16", seg_idx, seg_cnt); end
            seg_idx++;
            idle_run = 0;
         end
         if (grant == 2'b00) idle_run++;
         if (tx_valid && tx_ready) seg_cnt++;
         prev = grant;
      end
      total++;
      if (seg_idx != 4) begin bad++; $display("FAIL fair_segments got=%0d exp=4", seg_idx); end
   endtask

   task automatic test_backpressure();
      int xfers = 0;
      int s = 0;
      logic locked = 1'b0;
      logic done = 1'b0;
      push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04); push0(8'h0A);
      while (!done && s < 40) begin
         tx_ready_next = s[0] ? 1'b0 : 1'b1;
         step();
         total += 2;
         if (req_ready[0] !== (locked & tx_ready)) begin bad++; $display("FAIL bp_rdy0 step=%0d got=%b exp=%b", s, req_ready[0], locked & tx_ready); end
         if (req_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_rdy1 step=%0d got=%b exp=0", s, req_ready[1]); end
         if (tx_valid && tx_ready) begin
            xfers++;
            if (tx_data == 8'h0A) done = 1'b1;
         end
         locked = 1'b1;
         s++;
      end
      tx_ready_next = 1'b1;
      repeat (3) begin
         step();
         total++;
         if (tx_valid !== 1'b0) begin bad++; $display("FAIL bp_tail_valid got=%b exp=0", tx_valid); end
      end
      total++;
      if (xfers != 5) begin bad++; $display("FAIL bp_xfers got=%0d exp=5", xfers); end
   endtask

   task automatic test_timeout();
      int rel_k = 0;
      int seen = 0;
      int n;
      do_reset();
      push0(8'h55);
      for (int s = 0; s < 10 && seen == 0; s++) begin
         step();
         if (tx_valid && tx_ready) seen = 1;
      end
      total++;
      if (seen != 1) begin bad++; $display("FAIL to_first_byte got=%0d exp=1", seen); end
      push1(8'h31); push1(8'h0A);
      for (int k = 1; k <= 1200 && rel_k == 0; k++) begin
         step();
         if (grant == 2'b10) rel_k = k;
      end
      total++;
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (rel_k != 1002) begin bad++; $display("FAIL to_release got=%0d exp=1002", rel_k); end
      drain(n);
      total++;
      if (n >= 300 || exp_q1.size() != 0) begin bad++; $display("FAIL to_drain steps=%0d left=%0d exp=0", n, exp_q1.size()); end
`else
      if (grant !== 2'b01 || rel_k != 0) begin bad++; $display("FAIL to_held got=%b at=%0d exp=01", grant, rel_k); end
      n = 0;
      do_reset();
`endif
   endtask

   task automatic test_wrap();
      logic [2:0] starts[3];
      logic [2:0] exp_s[3];
      logic [2:0] prev = 3'b000;
      int ns = 0;
      int ok = 0;
      exp_s[0] = 3'b100; exp_s[1] = 3'b001; exp_s[2] = 3'b010;
      req_data3 = {3{8'h0A}};
      tx_ready3 = 1'b1;
      req_valid3 = 3'b010;
      for (int s = 0; s < 10 && ok < 2; s++) begin
         step();
         if (grant3 == 3'b010) ok = 1;
         else if (ok == 1 && busy3 == 1'b0) ok = 2;
      end
      total++;
      if (ok != 2) begin bad++; $display("FAIL wrap_setup got=%0d exp=2", ok); end
      req_valid3 = 3'b111;
      for (int s = 0; s < 20 && ns < 3; s++) begin
         step();
         if (grant3 != 3'b000 && prev == 3'b000) begin
            starts[ns] = grant3;
            total++;
            if (req_ready3 !== grant3 || tx_data3 !== 8'h0A) begin
               bad++;
               $display("FAIL wrap_ready got=%b data=%h exp=%b/0a", req_ready3, tx_data3, grant3);
            end
            ns++;
         end
         prev = grant3;
      end
      req_valid3 = 3'b000;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (i >= ns || starts[i] !== exp_s[i]) begin bad++; $display("FAIL wrap_order idx=%0d got=%b exp=%b", i, (i < ns) ? starts[i] : 3'bxxx, exp_s[i]); end
      end
   endtask

   initial begin
      req_valid = '0; req_data = '0; tx_ready = 1'b1; tx_ready_next = 1'b1;
      req_valid3 = '0; req_data3 = '0; tx_ready3 = 1'b1;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_timeout();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
